// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared definitions for the UART capture loader: UART frame
//             constants, receiver and loader state encodings, and the default
//             bit period.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // 8N1 framing
    localparam int c_DATA_BITS = 8;
    localparam int c_STOP_BITS = 1;

    // 100 MHz system clock at 115200 baud
    localparam int c_DEFAULT_CLOCKS_PER_BAUD = 868;

    // One-hot loader state encodings
    localparam logic [2:0] c_LOAD_ONEHOT  = 3'b001;
    localparam logic [2:0] c_READY_ONEHOT = 3'b010;
    localparam logic [2:0] c_PLAY_ONEHOT  = 3'b100;

    typedef enum logic [2:0] {
        ST_LOAD  = c_LOAD_ONEHOT,
        ST_READY = c_READY_ONEHOT,
        ST_PLAY  = c_PLAY_ONEHOT
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver: 2-flop synchronizer, start-bit glitch
//             filter, mid-bit sampling LSB first.
//  Ports    : clk, rst       - clock, synchronous active-high reset
//             rx_line        - asynchronous serial input (idles high)
//             rx_valid       - 1-cycle pulse, rx_data holds a good byte
//             rx_data        - received byte
//             rx_ferr        - 1-cycle pulse, stop bit was low (byte dropped)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = c_DEFAULT_CLOCKS_PER_BAUD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_line,
    output logic                   rx_valid,
    output logic [c_DATA_BITS-1:0] rx_data,
    output logic                   rx_ferr
);

    localparam int c_CW = $clog2(CLOCKS_PER_BAUD);
    localparam int c_BW = $clog2(c_DATA_BITS);
    localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [c_CW-1:0] c_FULL_LAST = c_CW'(CLOCKS_PER_BAUD - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(c_DATA_BITS - 1);

    logic [1:0]             r_sync;
    logic                   r_prev;
    rx_state_t              r_state;
    logic [c_CW-1:0]        r_cnt;
    logic [c_BW-1:0]        r_bit;
    logic [c_DATA_BITS-1:0] r_shift;
    logic                   w_line;

    assign w_line = r_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= 2'b11;
            r_prev   <= 1'b1;
            r_state  <= RX_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            rx_ferr  <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], rx_line};
            r_prev   <= w_line;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    // Edge (not level) start, so a line held low after a
                    // framing error does not retrigger
                    if (r_prev && !w_line) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_cnt == c_HALF_LAST) begin
                        r_cnt <= '0;
                        r_bit <= '0;
                        // Line back high at mid-start: glitch, no error
                        r_state <= w_line ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                RX_DATA: begin
                    if (r_cnt == c_FULL_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_line, r_shift[c_DATA_BITS-1:1]};
                        r_bit   <= r_bit + c_BW'(1);
                        if (r_bit == c_BIT_LAST) r_state <= RX_STOP;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                RX_STOP: begin
                    // Return to idle at mid-stop so a back-to-back start
                    // edge is not missed
                    if (r_cnt == c_FULL_LAST) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (w_line) begin
                            rx_valid <= 1'b1;
                            rx_data  <= r_shift;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
`default_nettype none
// ============================================================================
//  Module   : xilinx_true_dual_port_read_first_1_clock_ram
//  Purpose  : True dual-port, read-first block RAM on a single clock.
//             HIGH_PERFORMANCE adds an output register (2-cycle read latency);
//             LOW_LATENCY reads in 1 cycle.
//  Ports    : addra/addrb address, dina/dinb write data, wea/web write enable,
//             ena/enb port enable, rsta/rstb output register reset,
//             regcea/regceb output register enable, douta/doutb read data.
//  Revision : 1.0 - initial release
// ============================================================================
module xilinx_true_dual_port_read_first_1_clock_ram #(
    parameter int    RAM_WIDTH       = 18,
    parameter int    RAM_DEPTH       = 1024,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic [RAM_WIDTH-1:0]         dinb,
    input  logic                         clka,
    input  logic                         wea,
    input  logic                         web,
    input  logic                         ena,
    input  logic                         enb,
    input  logic                         rsta,
    input  logic                         rstb,
    input  logic                         regcea,
    input  logic                         regceb,
    output logic [RAM_WIDTH-1:0]         douta,
    output logic [RAM_WIDTH-1:0]         doutb
);

    logic [RAM_WIDTH-1:0] r_bram [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] r_ram_data_a;
    logic [RAM_WIDTH-1:0] r_ram_data_b;

    // Non-blocking reads return the pre-write contents (read-first)
    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) r_bram[addra] <= dina;
            r_ram_data_a <= r_bram[addra];
        end
        if (enb) begin
            if (web) r_bram[addrb] <= dinb;
            r_ram_data_b <= r_bram[addrb];
        end
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
            assign douta = r_ram_data_a;
            assign doutb = r_ram_data_b;
        end else begin : g_output_register
            always_ff @(posedge clka) begin
                if (rsta)        douta <= '0;
                else if (regcea) douta <= r_ram_data_a;
                if (rstb)        doutb <= '0;
                else if (regceb) doutb <= r_ram_data_b;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/uart_capture_loader.sv
`default_nettype none
// ============================================================================
//  Module   : uart_capture_loader
//  Purpose  : Receives a CAPTURE_LENGTH-byte waveform over UART into a
//             dual-port RAM and replays it as a valid/data sample stream at
//             one sample every SAMPLE_PERIOD cycles.
//  Ports    : clk, rst       - clock, synchronous active-high reset
//             uart_rx        - asynchronous serial input (idles high)
//             play           - 1-cycle replay request
//             axiov, axiod   - replayed sample valid / data
//             loaded         - a complete waveform is stored
//             busy           - replay in progress
//             error_count    - saturating count of framing errors and
//                              dropped bytes
//  Options  : UART_LOADER_CHECKSUM_EN - expect an XOR checksum byte after the
//             data; a mismatch discards the load.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_capture_loader
    import uart_pkg::*;
#(
    parameter int CAPTURE_LENGTH  = 1000,
    parameter int CLOCKS_PER_BAUD = c_DEFAULT_CLOCKS_PER_BAUD,
    parameter int SAMPLE_PERIOD   = 1,
    parameter int TIMEOUT_CYCLES  = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    input  logic       play,
    output logic       axiov,
    output logic [7:0] axiod,
    output logic       loaded,
    output logic       busy,
    output logic [7:0] error_count
);

    localparam int c_AW = $clog2(CAPTURE_LENGTH);
    localparam int c_RW = c_AW + 2;
    localparam int c_DW = $clog2(SAMPLE_PERIOD + 1);
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_AW-1:0] c_WADDR_LAST   = c_AW'(CAPTURE_LENGTH - 1);
    localparam logic [c_RW-1:0] c_RCNT_END     = c_RW'(CAPTURE_LENGTH);
    localparam logic [c_RW-1:0] c_RCNT_DONE    = c_RW'(CAPTURE_LENGTH + 2);
    localparam logic [c_DW-1:0] c_DIV_LAST     = c_DW'(SAMPLE_PERIOD - 1);
    localparam logic [c_TW-1:0] c_TIMEOUT_LAST = c_TW'(TIMEOUT_CYCLES - 1);

    logic                w_rx_valid;
    logic [7:0]          w_rx_data;
    logic                w_rx_ferr;
    loader_state_t       r_state;
    logic [c_AW-1:0]     r_waddr;
    logic [c_RW-1:0]     r_rcnt;
    logic [c_DW-1:0]     r_div;
    logic [c_TW-1:0]     r_tcnt;
    logic                r_v1;
    logic                r_v2;
    logic                w_issue;
    logic                w_we;
    logic [c_AW-1:0]     w_addra;
    logic                w_err_evt;
    logic                w_pending;
    logic                w_ck_wait;
    logic                w_ck_bad;
    logic [7:0]          w_doutb;
    logic [7:0]          w_douta_unused;

`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0] r_xor;
    logic       r_ck_wait;
    assign w_ck_wait = r_ck_wait;
    assign w_ck_bad  = (w_rx_data != r_xor);
`else
    assign w_ck_wait = 1'b0;
    assign w_ck_bad  = 1'b0;
`endif

    uart_rx #(
        .CLOCKS_PER_BAUD (CLOCKS_PER_BAUD)
    ) u_uart_rx (
        .clk      (clk),
        .rst      (rst),
        .rx_line  (uart_rx),
        .rx_valid (w_rx_valid),
        .rx_data  (w_rx_data),
        .rx_ferr  (w_rx_ferr)
    );

    xilinx_true_dual_port_read_first_1_clock_ram #(
        .RAM_WIDTH       (8),
        .RAM_DEPTH       (CAPTURE_LENGTH),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
    ) u_buffer (
        .addra  (w_addra),
        .addrb  (r_rcnt[c_AW-1:0]),
        .dina   (w_rx_data),
        .dinb   (8'h00),
        .clka   (clk),
        .wea    (w_we),
        .web    (1'b0),
        .ena    (1'b1),
        .enb    (1'b1),
        .rsta   (rst),
        .rstb   (rst),
        .regcea (1'b1),
        .regceb (1'b1),
        .douta  (w_douta_unused),
        .doutb  (w_doutb)
    );

    assign w_issue   = (r_state == ST_PLAY) && (r_rcnt < c_RCNT_END) && (r_div == '0);
    assign w_pending = (r_waddr != '0) || w_ck_wait;

    // Write path and error events. A new upload from READY restarts at 0.
    always_comb begin
        w_we      = 1'b0;
        w_addra   = r_waddr;
        w_err_evt = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_we      = w_rx_valid && !w_ck_wait;
                w_err_evt = w_rx_ferr || (w_rx_valid && w_ck_wait && w_ck_bad);
            end
            ST_READY: begin
                w_we      = w_rx_valid && !play;
                w_addra   = '0;
                w_err_evt = w_rx_ferr || (w_rx_valid && play);
            end
            ST_PLAY: begin
                w_err_evt = w_rx_valid || w_rx_ferr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_LOAD;
            r_waddr     <= '0;
            r_rcnt      <= '0;
            r_div       <= '0;
            r_tcnt      <= '0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            axiov       <= 1'b0;
            axiod       <= '0;
            loaded      <= 1'b0;
            busy        <= 1'b0;
            error_count <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            r_xor       <= '0;
            r_ck_wait   <= 1'b0;
`endif
        end else begin
            // Valid follows the 2-cycle RAM read, then the output register
            r_v1  <= w_issue;
            r_v2  <= r_v1;
            axiov <= r_v2;
            if (r_v2) axiod <= w_doutb;

            if (w_err_evt && (error_count != 8'hFF))
                error_count <= error_count + 8'd1;

            case (r_state)
                ST_LOAD: begin
                    if (w_rx_ferr) begin
                        r_waddr <= '0;
                        r_tcnt  <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
                        r_ck_wait <= 1'b0;
`endif
                    end else if (w_rx_valid) begin
                        r_tcnt <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
                        if (r_ck_wait) begin
                            r_ck_wait <= 1'b0;
                            if (!w_ck_bad) begin
                                loaded  <= 1'b1;
                                r_state <= ST_READY;
                            end
                        end else begin
                            r_xor <= (r_waddr == '0) ? w_rx_data : (r_xor ^ w_rx_data);
                            if (r_waddr == c_WADDR_LAST) begin
                                r_waddr   <= '0;
                                r_ck_wait <= 1'b1;
                            end else begin
                                r_waddr <= r_waddr + c_AW'(1);
                            end
                        end
`else
                        if (r_waddr == c_WADDR_LAST) begin
                            r_waddr <= '0;
                            loaded  <= 1'b1;
                            r_state <= ST_READY;
                        end else begin
                            r_waddr <= r_waddr + c_AW'(1);
                        end
`endif
                    end else if (w_pending) begin
                        // Partial load abandoned after a long idle gap
                        if (r_tcnt == c_TIMEOUT_LAST) begin
                            r_tcnt  <= '0;
                            r_waddr <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
                            r_ck_wait <= 1'b0;
`endif
                        end else begin
                            r_tcnt <= r_tcnt + c_TW'(1);
                        end
                    end else begin
                        r_tcnt <= '0;
                    end
                end
                ST_READY: begin
                    r_tcnt <= '0;
                    if (play) begin
                        busy    <= 1'b1;
                        r_rcnt  <= '0;
                        r_div   <= '0;
                        r_state <= ST_PLAY;
                    end else if (w_rx_valid) begin
                        // Byte 0 of a new upload is written this cycle
                        loaded  <= 1'b0;
                        r_waddr <= c_AW'(1);
                        r_state <= ST_LOAD;
`ifdef UART_LOADER_CHECKSUM_EN
                        r_xor   <= w_rx_data;
`endif
                    end
                end
                ST_PLAY: begin
                    r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + c_DW'(1);
                    if (w_issue) begin
                        r_rcnt <= r_rcnt + c_RW'(1);
                    end else if (r_rcnt >= c_RCNT_END) begin
                        // Past the last address: count out the read pipeline
                        if (r_rcnt == c_RCNT_DONE) begin
                            r_rcnt  <= '0;
                            busy    <= 1'b0;
                            r_state <= ST_READY;
                        end else begin
                            r_rcnt <= r_rcnt + c_RW'(1);
                        end
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_capture_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_capture_loader
//  Purpose  : Directed self-checking bench for uart_capture_loader with a
//             scoreboard queue of expected replay samples.
//  Options  : UART_LOADER_CHECKSUM_EN - sends checksum bytes and runs the
//             checksum match/mismatch steps.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_capture_loader;

    localparam int CL  = 8;
    localparam int CPB = 16;
    localparam int SP  = 1;
    localparam int TO  = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       play = 1'b0;
    logic       axiov;
    logic [7:0] axiod;
    logic       loaded;
    logic       busy;
    logic [7:0] error_count;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_capture_loader #(
        .CAPTURE_LENGTH  (CL),
        .CLOCKS_PER_BAUD (CPB),
        .SAMPLE_PERIOD   (SP),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx     (uart_rx),
        .play        (play),
        .axiov       (axiov),
        .axiod       (axiod),
        .loaded      (loaded),
        .busy        (busy),
        .error_count (error_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every replayed sample must match the next expected byte
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst && axiov) begin
            if (exp_q.size() == 0) begin
                check("spurious_axiov", 32'(axiov), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("axiod", 32'(axiod), 32'(e));
            end
        end
    end

    // Caller is at a negedge; frame starts immediately (no idle gap)
    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        if (!stop) repeat (CPB) @(negedge clk);
    endtask

    task automatic send_run(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) send_byte(first + 8'(i), 1'b1);
    endtask

    function automatic logic [7:0] xor_run(input logic [7:0] first, input int n);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < n; i++) x = x ^ (first + 8'(i));
        return x;
    endfunction

    task automatic send_cs(input logic [7:0] cs);
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(cs, 1'b1);
`else
        if (cs === 8'hxx) $display("unused checksum");
`endif
    endtask

    // Pulse play at a negedge and check the replay window cycle by cycle
    task automatic play_and_check(input logic [7:0] first);
        for (int i = 0; i < CL; i++) exp_q.push_back(first + 8'(i));
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
        check("busy_set", 32'(busy), 32'd1);
        check("axiov_lat0", 32'(axiov), 32'd0);
        @(negedge clk);
        check("axiov_lat1", 32'(axiov), 32'd0);
        @(negedge clk);
        check("axiov_lat2", 32'(axiov), 32'd0);
        for (int i = 0; i < CL; i++) begin
            @(negedge clk);
            check("axiov_run", 32'(axiov), 32'd1);
            check("busy_run", 32'(busy), 32'd1);
        end
        @(negedge clk);
        check("axiov_end", 32'(axiov), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
        check("loaded_kept", 32'(loaded), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_axiov", 32'(axiov), 32'd0);
        check("rst_axiod", 32'(axiod), 32'd0);
        check("rst_loaded", 32'(loaded), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_errors", 32'(error_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic load and replay
        send_run(8'h01, CL);
        send_cs(xor_run(8'h01, CL));
        @(negedge clk);
        check("load1_loaded", 32'(loaded), 32'd1);
        play_and_check(8'h01);
        check("load1_errors", 32'(error_count), 32'd0);

        // Framing error mid-load restarts the upload
        send_run(8'h31, 3);
        check("reupload_loaded", 32'(loaded), 32'd0);
        send_byte(8'h55, 1'b0);
        check("ferr_count", 32'(error_count), 32'd1);
        send_run(8'hA0, CL);
        send_cs(xor_run(8'hA0, CL));
        @(negedge clk);
        check("load2_loaded", 32'(loaded), 32'd1);
        play_and_check(8'hA0);
        check("load2_errors", 32'(error_count), 32'd1);

        // Idle timeout discards a partial load
        do_reset();
        send_run(8'h40, 4);
        repeat (TO) @(negedge clk);
        check("timeout_loaded", 32'(loaded), 32'd0);
        send_run(8'h10, CL);
        send_cs(xor_run(8'h10, CL));
        @(negedge clk);
        check("load3_loaded", 32'(loaded), 32'd1);
        play_and_check(8'h10);
        check("load3_errors", 32'(error_count), 32'd0);

        // Start-bit glitch in the middle of a load is ignored
        send_run(8'h20, 3);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("glitch_errors", 32'(error_count), 32'd0);
        check("glitch_loaded", 32'(loaded), 32'd0);
        send_run(8'h23, CL - 3);
        send_cs(xor_run(8'h20, CL));
        @(negedge clk);
        check("load4_loaded", 32'(loaded), 32'd1);
        play_and_check(8'h20);

        // Byte arriving during replay is dropped and counted
        fork
            send_byte(8'h99, 1'b1);
            begin
                repeat (149) @(negedge clk);
                play_and_check(8'h20);
            end
        join
        repeat (4) @(negedge clk);
        check("drop_errors", 32'(error_count), 32'd1);
        check("drop_loaded", 32'(loaded), 32'd1);
        play_and_check(8'h20);

        // Reset in the middle of a replay
        for (int i = 0; i < CL; i++) exp_q.push_back(8'h20 + 8'(i));
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_axiov", 32'(axiov), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_axiov", 32'(axiov), 32'd0);
        check("mid_rst_loaded", 32'(loaded), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_errors", 32'(error_count), 32'd0);
        exp_q.delete();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_axiov", 32'(axiov), 32'd0);

`ifdef UART_LOADER_CHECKSUM_EN
        // Checksum mismatch then match
        send_run(8'h01, CL);
        send_byte(8'h00, 1'b1);
        @(negedge clk);
        check("cs_bad_loaded", 32'(loaded), 32'd0);
        check("cs_bad_errors", 32'(error_count), 32'd1);
        send_run(8'h01, CL);
        send_byte(8'h08, 1'b1);
        @(negedge clk);
        check("cs_good_loaded", 32'(loaded), 32'd1);
        play_and_check(8'h01);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
